// File: rtl/mov_dispatch_ctrl.sv
// mov_dispatch_ctrl: initiator side of the MOV handshake.
// Accepts 16-bit instruction words, decodes and legality-checks them, issues
// the MOV start code plus operands to the MOV sub-FSM, waits for done and
// retires the instruction or raises a one-cycle error with a cause code.
// Optional feature macro: DISPATCH_STATS_EN enables the retired-MOV counter;
// when undefined, retired_count is tied to zero.
module mov_dispatch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [3:0]  MOV_OPCODE     = 4'b1010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  FSM_start,
  output logic [5:0]  source,
  output logic [5:0]  dest,
  input  logic        done,
  output logic        busy,
  output logic        retire,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RETIRE = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // Last WAIT count value that is still allowed to see done.
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] NOP_OPCODE  = 4'b0000;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OPERAND = 2'b11;

  state_t      r_state;
  logic [15:0] r_instr;
  logic [7:0]  r_wait_cnt;
  logic        r_ready;
  logic [3:0]  r_start;
  logic [5:0]  r_source;
  logic [5:0]  r_dest;
  logic        r_busy;
  logic        r_retire;
  logic        r_error;
  logic [1:0]  r_err_code;

  // Field decode of the held instruction.
  logic [3:0] w_opcode;
  logic [5:0] w_src;
  logic [5:0] w_dst;
  logic       w_operands_ok;

  assign w_opcode      = r_instr[15:12];
  assign w_src         = r_instr[11:6];
  assign w_dst         = r_instr[5:0];
  // Source may name a register (0-4), I0 (5) or I1 (6); dest only 0-5.
  assign w_operands_ok = (w_src <= 6'd6) && (w_dst <= 6'd5);

  // Dispatch FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_instr    <= 16'h0000;
      r_wait_cnt <= 8'd0;
      r_ready    <= 1'b0;
      r_start    <= 4'b0000;
      r_source   <= 6'd0;
      r_dest     <= 6'd0;
      r_busy     <= 1'b0;
      r_retire   <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_start  <= 4'b0000;
      r_retire <= 1'b0;
      r_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid && r_ready) begin
            r_instr    <= instr;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_err_code <= ERR_NONE;
            r_state    <= S_DECODE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_opcode == NOP_OPCODE) begin
            r_retire <= 1'b1;
            r_state  <= S_RETIRE;
          end else if ((w_opcode == MOV_OPCODE) && w_operands_ok) begin
            r_start  <= MOV_OPCODE;
            r_source <= w_src;
            r_dest   <= w_dst;
            r_state  <= S_ISSUE;
          end else if (w_opcode == MOV_OPCODE) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_OPERAND;
            r_state    <= S_ERR;
          end else begin
            r_error    <= 1'b1;
            r_err_code <= ERR_OPCODE;
            r_state    <= S_ERR;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= 8'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over an expiring timeout in the same cycle.
          if (done) begin
            r_retire <= 1'b1;
            r_state  <= S_RETIRE;
          end else if (r_wait_cnt == TO_LAST) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_RETIRE, S_ERR: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign FSM_start   = r_start;
  assign source      = r_source;
  assign dest        = r_dest;
  assign busy        = r_busy;
  assign retire      = r_retire;
  assign error       = r_error;
  assign err_code    = r_err_code;

`ifdef DISPATCH_STATS_EN
  logic [15:0] r_retired_count;
  logic        w_mov_retire;

  // Only MOVs pass through WAIT, so done seen there marks a MOV retirement.
  assign w_mov_retire = (r_state == S_WAIT) && done;

  // Retired-MOV counter, wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retired_count <= 16'h0000;
    end else if (w_mov_retire) begin
      r_retired_count <= r_retired_count + 16'h0001;
    end else begin
      r_retired_count <= r_retired_count;
    end
  end

  assign retired_count = r_retired_count;
`else
  assign retired_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mov_dispatch_ctrl.sv
// Directed self-checking bench for mov_dispatch_ctrl.
// Cycle N is the cycle whose closing edge accepts an instruction; outputs
// are sampled 1 time unit after each rising edge.
module tb_mov_dispatch_ctrl;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  FSM_start;
  logic [5:0]  source;
  logic [5:0]  dest;
  logic        done;
  logic        busy;
  logic        retire;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] retired_count;

  int          n_checks;
  int          n_errors;
  logic [15:0] model_count;

  mov_dispatch_ctrl #(
    .TIMEOUT_CYCLES(15),
    .MOV_OPCODE    (4'b1010)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .FSM_start    (FSM_start),
    .source       (source),
    .dest         (dest),
    .done         (done),
    .busy         (busy),
    .retire       (retire),
    .error        (error),
    .err_code     (err_code),
    .retired_count(retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Model of a MOV retirement for the optional counter.
  task automatic note_mov_retire();
`ifdef DISPATCH_STATS_EN
    model_count = model_count + 16'h0001;
`endif
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    done        = 1'b0;
    tick(1);
    reset = 1'b0;
`ifdef DISPATCH_STATS_EN
    model_count = 16'h0000;
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_ready"}, 32'(instr_ready), 32'd0);
    check_val({tag, "_start"}, 32'(FSM_start), 32'd0);
    check_val({tag, "_src"},   32'(source), 32'd0);
    check_val({tag, "_dst"},   32'(dest), 32'd0);
    check_val({tag, "_busy"},  32'(busy), 32'd0);
    check_val({tag, "_ret"},   32'(retire), 32'd0);
    check_val({tag, "_err"},   32'(error), 32'd0);
    check_val({tag, "_code"},  32'(err_code), 32'd0);
    check_val({tag, "_cnt"},   32'(retired_count), 32'd0);
  endtask

  // Present one word for one cycle; returns at cycle N+1.
  task automatic accept(input string tag, input logic [15:0] word);
    check_val({tag, "_ready_pre"}, 32'(instr_ready), 32'd1);
    instr       = word;
    instr_valid = 1'b1;
    tick(1);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    check_val({tag, "_busy_dec"},  32'(busy), 32'd1);
    check_val({tag, "_ready_dec"}, 32'(instr_ready), 32'd0);
    check_val({tag, "_code_dec"},  32'(err_code), 32'd0);
  endtask

  // Illegal word: error at N+2, idle again at N+3.
  task automatic illegal(input string tag, input logic [15:0] word, input logic [1:0] code);
    accept(tag, word);
    tick(1);
    check_val({tag, "_err"},   32'(error), 32'd1);
    check_val({tag, "_code"},  32'(err_code), 32'(code));
    check_val({tag, "_start"}, 32'(FSM_start), 32'd0);
    check_val({tag, "_ret"},   32'(retire), 32'd0);
    tick(1);
    check_val({tag, "_err_end"},  32'(error), 32'd0);
    check_val({tag, "_code_hld"}, 32'(err_code), 32'(code));
    check_val({tag, "_ready"},    32'(instr_ready), 32'd1);
    check_val({tag, "_busy"},     32'(busy), 32'd0);
    check_val({tag, "_start2"},   32'(FSM_start), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    model_count = 16'h0000;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    done        = 1'b0;

    // Reset cycle: everything at reset values, ready rises the cycle after.
    reset = 1'b1;
    tick(1);
    check_reset_values("rst");
    reset = 1'b0;
    tick(1);
    check_val("rst_ready_after", 32'(instr_ready), 32'd1);
    check_val("rst_busy_after",  32'(busy), 32'd0);

    // MOV src=3 dest=5, done high during N+7 and N+8.
    accept("mov1", 16'hA0C5);
    check_val("mov1_start_dec", 32'(FSM_start), 32'd0);
    tick(1);
    check_val("mov1_start_iss", 32'(FSM_start), 32'hA);
    check_val("mov1_src",       32'(source), 32'd3);
    check_val("mov1_dst",       32'(dest), 32'd5);
    tick(1);
    check_val("mov1_start_wait", 32'(FSM_start), 32'd0);
    tick(4);
    check_val("mov1_ret_n7", 32'(retire), 32'd0);
    check_val("mov1_busy_n7", 32'(busy), 32'd1);
    done = 1'b1;
    tick(1);
    note_mov_retire();
    check_val("mov1_ret_n8", 32'(retire), 32'd1);
    check_val("mov1_err_n8", 32'(error), 32'd0);
    check_val("mov1_cnt",    32'(retired_count), 32'(model_count));
    tick(1);
    done = 1'b0;
    check_val("mov1_ret_n9",   32'(retire), 32'd0);
    check_val("mov1_busy_n9",  32'(busy), 32'd0);
    check_val("mov1_ready_n9", 32'(instr_ready), 32'd1);
    check_val("mov1_src_hold", 32'(source), 32'd3);
    check_val("mov1_dst_hold", 32'(dest), 32'd5);

    // NOP: retire at N+2, no start, counter unchanged.
    accept("nop", 16'h0000);
    tick(1);
    check_val("nop_ret",   32'(retire), 32'd1);
    check_val("nop_start", 32'(FSM_start), 32'd0);
    check_val("nop_cnt",   32'(retired_count), 32'(model_count));
    tick(1);
    check_val("nop_ready", 32'(instr_ready), 32'd1);
    check_val("nop_ret2",  32'(retire), 32'd0);

    // Illegal instructions.
    illegal("badop",  16'h3041, 2'b01);
    illegal("badsrc", 16'hA1C2, 2'b11);
    illegal("baddst", 16'hA006, 2'b11);

    // Timeout: WAIT spans N+3..N+17, error at N+18.
    accept("to", 16'hA0C5);
    tick(16);
    check_val("to_err_n17",  32'(error), 32'd0);
    check_val("to_busy_n17", 32'(busy), 32'd1);
    tick(1);
    check_val("to_err_n18",  32'(error), 32'd1);
    check_val("to_code",     32'(err_code), 32'd2);
    check_val("to_ret_n18",  32'(retire), 32'd0);
    tick(1);
    check_val("to_ready_n19", 32'(instr_ready), 32'd1);
    check_val("to_err_n19",   32'(error), 32'd0);

    // done on the final WAIT cycle wins over timeout.
    accept("tolast", 16'hA0C5);
    tick(16);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    note_mov_retire();
    check_val("tolast_ret", 32'(retire), 32'd1);
    check_val("tolast_err", 32'(error), 32'd0);
    check_val("tolast_cnt", 32'(retired_count), 32'(model_count));
    tick(1);
    check_val("tolast_ready", 32'(instr_ready), 32'd1);
    check_val("tolast_err2",  32'(error), 32'd0);

    // Reset during WAIT, then a stray done: silent abort.
    accept("rw", 16'hA0C5);
    tick(4);
    check_val("rw_busy_wait", 32'(busy), 32'd1);
    do_reset();
    check_reset_values("rw_rst");
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check_val("rw_ret1", 32'(retire), 32'd0);
    check_val("rw_err1", 32'(error), 32'd0);
    check_val("rw_ready", 32'(instr_ready), 32'd1);
    tick(1);
    check_val("rw_ret2",  32'(retire), 32'd0);
    check_val("rw_err2",  32'(error), 32'd0);
    check_val("rw_busy2", 32'(busy), 32'd0);
    accept("rw_mov", 16'hA0C5);
    tick(1);
    check_val("rw_mov_start", 32'(FSM_start), 32'hA);
    tick(1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    note_mov_retire();
    check_val("rw_mov_ret", 32'(retire), 32'd1);
    tick(1);

    // Reset, then three back-to-back MOVs, each done after four WAIT cycles.
    do_reset();
    tick(1);
    for (int k = 0; k < 3; k++) begin
      accept("b2b", 16'hA0C5);
      tick(1);
      check_val("b2b_start_iss", 32'(FSM_start), 32'hA);
      tick(1);
      check_val("b2b_start_wait", 32'(FSM_start), 32'd0);
      tick(3);
      check_val("b2b_ret_pre", 32'(retire), 32'd0);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      note_mov_retire();
      check_val("b2b_ret", 32'(retire), 32'd1);
      tick(1);
    end
    check_val("b2b_cnt", 32'(retired_count), 32'(model_count));
`ifdef DISPATCH_STATS_EN
    check_val("b2b_cnt3", 32'(retired_count), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
